// File: rtl/iq_playback_fifo_pkg.sv
// Shared constants for the IQ playback FIFO: state encoding, reset defaults
// and the depth helper used by the controller.
package iq_playback_fifo_pkg;

   localparam int unsigned DEF_WIDTH    = 16;
   localparam int unsigned DEF_ADDR_W   = 10;
   localparam int unsigned DEF_IW       = 16;
   localparam int unsigned CFG_W        = 16;
   localparam int unsigned DEF_INTERVAL = 1;
   localparam int unsigned DEF_THRESH   = 0;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_PRIME = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;

   // Number of I/Q pair slots for a given address width
   function automatic int unsigned depth_of(input int unsigned aw);
      return 32'd1 << aw;
   endfunction

endpackage

// File: rtl/iq_playback_fifo_if.sv
// Host command / sample output bundle for the IQ playback FIFO.
// The loop signal exists only when IQ_PLAYBACK_LOOP_EN is defined.
interface iq_playback_fifo_if
   import iq_playback_fifo_pkg::*;
#(
   parameter int unsigned WIDTH  = DEF_WIDTH,
   parameter int unsigned ADDR_W = DEF_ADDR_W
);
   logic [CFG_W-1:0]        cfg_data;
   logic                    wr;
   logic                    wr_sync;
   logic                    set_interp;
   logic                    set_thresh;
   logic                    start;
   logic                    stop;
`ifdef IQ_PLAYBACK_LOOP_EN
   logic                    loop;
`endif
   logic                    out_strobe;
   logic signed [WIDTH-1:0] out_i;
   logic signed [WIDTH-1:0] out_q;
   logic [ADDR_W:0]         fill;
   logic                    full;
   logic                    empty;
   logic                    running;
   logic                    underflow;
   logic                    overflow;

   modport master (
      output cfg_data, wr, wr_sync, set_interp, set_thresh, start, stop,
`ifdef IQ_PLAYBACK_LOOP_EN
      output loop,
`endif
      input  out_strobe, out_i, out_q, fill, full, empty, running, underflow, overflow
   );

   modport slave (
      input  cfg_data, wr, wr_sync, set_interp, set_thresh, start, stop,
`ifdef IQ_PLAYBACK_LOOP_EN
      input  loop,
`endif
      output out_strobe, out_i, out_q, fill, full, empty, running, underflow, overflow
   );

endinterface

// File: rtl/iq_pair_ram.sv
// Simple dual-port pair storage: one write port, one registered read port.
module iq_pair_ram #(
   parameter int unsigned DW = 32,
   parameter int unsigned AW = 10
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);
   localparam int unsigned DEPTH = 32'd1 << AW;

   logic [DW-1:0] r_mem [DEPTH];
   logic [DW-1:0] r_rdata;

   // Write port
   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   // Registered read; holds the last popped word between reads
   always_ff @(posedge i_clk) begin
      if (i_re) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/iq_playback_fifo.sv
// IQ playback FIFO: host pushes interleaved I/Q words, the block paces pairs
// out at the programmed interpolation interval with a one-cycle strobe.
// Optional replay mode is compiled in with IQ_PLAYBACK_LOOP_EN.
module iq_playback_fifo
   import iq_playback_fifo_pkg::*;
#(
   parameter int unsigned WIDTH  = DEF_WIDTH,
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned IW     = DEF_IW
) (
   input  logic             adc_clk,
   input  logic             reset,
   iq_playback_fifo_if.slave bus
);
   localparam int unsigned DEPTH = depth_of(ADDR_W);
   localparam int unsigned DW    = 2 * WIDTH;
   localparam int unsigned FW    = ADDR_W + 1;

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic [IW-1:0]     r_interval;
   logic [IW-1:0]     r_cnt;
   logic [FW-1:0]     r_thresh;
   logic [FW-1:0]     r_fill;
   logic [FW-1:0]     w_fill_nxt;
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W-1:0] w_rd_ptr_nxt;
   logic              r_ptr_q;
   logic [WIDTH-1:0]  r_hold_i;
   logic              r_strobe;
   logic              r_zero;
   logic              r_full;
   logic              r_empty;
   logic              r_running;
   logic              r_underflow;
   logic              r_overflow;

   logic [IW-1:0]     w_reload;
   logic              w_loop;
   logic              w_tc;
   logic              w_pop;
   logic              w_consume;
   logic              w_underrun;
   logic              w_word_is_q;
   logic              w_commit;
   logic              w_push;
   logic              w_drop;
   logic              w_start_ok;
   logic [DW-1:0]     w_rd_data;

`ifdef IQ_PLAYBACK_LOOP_EN
   assign w_loop = bus.loop & (r_state == ST_RUN);
`else
   assign w_loop = 1'b0;
`endif

   // Interval 0 behaves as 1, so the reload value saturates at 0
   assign w_reload    = (r_interval == '0) ? '0 : r_interval - IW'(1);
   assign w_tc        = (r_state == ST_RUN) && (r_cnt == '0) && !bus.stop;
   assign w_pop       = w_tc && (r_fill != '0);
   assign w_consume   = w_pop && !w_loop;
   assign w_underrun  = w_tc && (r_fill == '0);
   assign w_word_is_q = r_ptr_q && !bus.wr_sync;
   assign w_commit    = bus.wr && w_word_is_q && !bus.stop;
   assign w_push      = w_commit && !r_full && !w_loop;
   assign w_drop      = w_commit && (r_full || w_loop);
   assign w_start_ok  = (r_state == ST_IDLE) && bus.start && !bus.stop;

   // Next-state decode; stop overrides everything
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (bus.start) w_state_nxt = ST_PRIME;
         ST_PRIME: if (r_fill >= r_thresh) w_state_nxt = ST_RUN;
         ST_RUN:   w_state_nxt = ST_RUN;
         default:  w_state_nxt = ST_IDLE;
      endcase
      if (bus.stop) w_state_nxt = ST_IDLE;
   end

   // State register and running flag
   always_ff @(posedge adc_clk or posedge reset) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_running <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_running <= (w_state_nxt == ST_RUN);
      end
   end

   // Fill accounting: simultaneous push and consume leaves fill unchanged
   always_comb begin
      w_fill_nxt = r_fill;
      if (bus.stop)                   w_fill_nxt = '0;
      else if (w_push && !w_consume)  w_fill_nxt = r_fill + FW'(1);
      else if (w_consume && !w_push)  w_fill_nxt = r_fill - FW'(1);
   end

   // Read pointer advance; in replay mode it wraps over the stored pairs
   always_comb begin
      w_rd_ptr_nxt = r_rd_ptr + ADDR_W'(1);
      if (w_loop && ({1'b0, r_rd_ptr} >= (r_fill - FW'(1)))) w_rd_ptr_nxt = '0;
   end

   // Fill, full/empty and FIFO pointers
   always_ff @(posedge adc_clk or posedge reset) begin
      if (reset) begin
         r_fill   <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         r_fill  <= w_fill_nxt;
         r_full  <= (w_fill_nxt == FW'(DEPTH));
         r_empty <= (w_fill_nxt == '0);
         if (bus.stop) begin
            r_rd_ptr <= r_wr_ptr;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (w_pop)  r_rd_ptr <= w_rd_ptr_nxt;
         end
      end
   end

   // I/Q word pairing; wr_sync realigns before the same-cycle word is taken
   always_ff @(posedge adc_clk or posedge reset) begin
      if (reset) begin
         r_ptr_q  <= 1'b0;
         r_hold_i <= '0;
      end else if (bus.stop) begin
         r_ptr_q  <= 1'b0;
      end else if (bus.wr) begin
         if (w_word_is_q) begin
            r_ptr_q  <= 1'b0;
         end else begin
            r_hold_i <= bus.cfg_data[WIDTH-1:0];
            r_ptr_q  <= 1'b1;
         end
      end else if (bus.wr_sync) begin
         r_ptr_q <= 1'b0;
      end
   end

   // Interval and prime threshold registers
   always_ff @(posedge adc_clk or posedge reset) begin
      if (reset) begin
         r_interval <= IW'(DEF_INTERVAL);
         r_thresh   <= FW'(DEF_THRESH);
      end else begin
         if (bus.set_interp) r_interval <= bus.cfg_data[IW-1:0];
         if (bus.set_thresh) r_thresh   <= bus.cfg_data[ADDR_W:0];
      end
   end

   // Interval down-counter: loaded on RUN entry, reloaded at terminal count
   always_ff @(posedge adc_clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (r_state != ST_RUN) begin
         if (w_state_nxt == ST_RUN) r_cnt <= w_reload;
      end else if (r_cnt == '0) begin
         r_cnt <= w_reload;
      end else begin
         r_cnt <= r_cnt - IW'(1);
      end
   end

   // Strobe, output zeroing and sticky error flags
   always_ff @(posedge adc_clk or posedge reset) begin
      if (reset) begin
         r_strobe    <= 1'b0;
         r_zero      <= 1'b1;
         r_underflow <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_strobe <= w_tc;
         if (bus.stop || w_underrun) r_zero <= 1'b1;
         else if (w_pop)             r_zero <= 1'b0;
         if (w_start_ok)      r_underflow <= 1'b0;
         else if (w_underrun) r_underflow <= 1'b1;
         if (w_drop)          r_overflow <= 1'b1;
         else if (w_start_ok) r_overflow <= 1'b0;
      end
   end

   iq_pair_ram #(
      .DW (DW),
      .AW (ADDR_W)
   ) u_ram (
      .i_clk   (adc_clk),
      .i_we    (w_push),
      .i_waddr (r_wr_ptr),
      .i_wdata ({r_hold_i, bus.cfg_data[WIDTH-1:0]}),
      .i_re    (w_pop),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rd_data)
   );

   assign bus.out_strobe = r_strobe;
   assign bus.out_i      = r_zero ? '0 : w_rd_data[DW-1:WIDTH];
   assign bus.out_q      = r_zero ? '0 : w_rd_data[WIDTH-1:0];
   assign bus.fill       = r_fill;
   assign bus.full       = r_full;
   assign bus.empty      = r_empty;
   assign bus.running    = r_running;
   assign bus.underflow  = r_underflow;
   assign bus.overflow   = r_overflow;

endmodule
